// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB initiator bridge and its helpers.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  // Low address bits that must be zero for a word-aligned transfer.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/apb_timeout_counter.sv
// Saturating wait-state counter; flags the increment that reaches the timeout limit.
module apb_timeout_counter
  import apb_master_pkg::*;
#(
  parameter int unsigned TimeoutCycles = DEFAULT_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] SatVal  = (TimeoutCycles == 0) ? '1 : CntW'(TimeoutCycles);
  localparam logic [CntW-1:0] LastVal = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != SatVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires during the wait cycle whose increment brings the count to the limit.
  assign expired_o = (TimeoutCycles != 0) && inc_i && (cnt_q == LastVal);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 initiator: turns single-beat valid/ready requests into SETUP/ACCESS transfers
// with wait-state handling, PSLVERR capture and a stall timeout.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e state_q, state_d;

  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;

  logic aligned;
  logic expired;

  assign aligned = (req_addr[1:0] & ALIGN_MASK) == 2'b00;

  apb_timeout_counter #(
    .TimeoutCycles(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (PCLK),
    .rst_ni   (PRESETn),
    .clr_i    ((state_q == IDLE) && (state_d == SETUP)),
    .inc_i    ((state_q == ACCESS) && !PREADY),
    .expired_o(expired)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = aligned ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || expired) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the FSM.
  always_comb begin
    req_ready_d   = (state_d == IDLE);
    rsp_valid_d   = (state_d == RESP);
    psel_d        = (state_d == SETUP) || (state_d == ACCESS);
    penable_d     = (state_d == ACCESS);
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;

    if ((state_q == IDLE) && req_valid) begin
      if (aligned) begin
        pwrite_d = req_write;
        paddr_d  = req_addr;
        pwdata_d = req_wdata;
      end else begin
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b1;
        rsp_timeout_d = 1'b0;
      end
    end

    if (state_q == ACCESS) begin
      if (PREADY) begin
        rsp_rdata_d   = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
        rsp_err_d     = PSLVERR;
        rsp_timeout_d = 1'b0;
      end else if (expired) begin
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b1;
        rsp_timeout_d = 1'b1;
      end
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: APB register-file slave with programmable waits/errors
// and a transaction-level model of latency and response contents.
module tb_apb_master_bridge;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  // Slave: timer-style register file, ready after slv_wait low ACCESS cycles.
  logic [31:0] smem [16] = '{default: '0};
  int          acc_q = 0;
  int          slv_wait = 0;
  bit          slv_stuck = 1'b0;
  bit          slv_err = 1'b0;

  assign PREADY  = PSEL && PENABLE && !slv_stuck && (acc_q >= slv_wait);
  assign PSLVERR = PREADY ? slv_err : 1'b1;
  assign PRDATA  = PREADY ? smem[PADDR[5:2]] : 32'hDEAD_BEEF;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_q <= acc_q + 1;
    else acc_q <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && !slv_err) smem[PADDR[5:2]] <= PWDATA;
  end

  // Reference model of the register file contents.
  logic [31:0] mmem [16] = '{default: '0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with the bridge idle again.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int wait_n, input bit stuck, input bit err, input int hold);
    bit          mis = (addr[1:0] != 2'b00);
    int          exp_lat;
    bit          exp_err;
    bit          exp_to;
    logic [31:0] exp_rd;
    int          lat = -1;
    bit          psel_seen = 1'b0;
    bit          unstable = 1'b0;
    int          idx = int'(addr[5:2]);

    if (mis) begin
      exp_lat = 1; exp_err = 1'b1; exp_to = 1'b0; exp_rd = '0;
    end else if (stuck || wait_n >= int'(TO)) begin
      exp_lat = 2 + int'(TO); exp_err = 1'b1; exp_to = 1'b1; exp_rd = '0;
    end else begin
      exp_lat = 3 + wait_n; exp_err = err; exp_to = 1'b0;
      exp_rd  = (!wr && !err) ? mmem[idx] : 32'h0;
      if (wr && !err) mmem[idx] = wdata;
    end

    slv_wait  = wait_n;
    slv_stuck = stuck;
    slv_err   = err;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;

    for (int e = 1; e <= 40; e++) begin
      @(posedge PCLK);
      #1;
      if (e == 1) begin
        req_valid = 1'b0;
        check("req_ready_busy", 64'(req_ready), 64'(0));
        if (!mis) check("setup_phase", 64'({PSEL, PENABLE}), 64'(2'b10));
      end
      if (!mis && e == 2) check("access_phase", 64'({PSEL, PENABLE}), 64'(2'b11));
      if (PSEL) begin
        psel_seen = 1'b1;
        if (PADDR !== addr || PWRITE !== wr || (wr && PWDATA !== wdata)) unstable = 1'b1;
      end
      if (rsp_valid) begin
        lat = e;
        break;
      end
    end

    check("rsp_latency", 64'(lat), 64'(exp_lat));
    check("psel_activity", 64'(psel_seen), 64'(!mis));
    check("apb_stable", 64'(unstable), 64'(0));

    if (lat < 0) begin
      PRESETn = 1'b0;
      @(posedge PCLK);
      #1;
      PRESETn = 1'b1;
      slv_stuck = 1'b0;
      return;
    end

    check("rsp_fields", 64'({PSEL, PENABLE, rsp_err, rsp_timeout, rsp_rdata}),
          64'({2'b00, exp_err, exp_to, exp_rd}));
    for (int h = 0; h < hold; h++) begin
      @(posedge PCLK);
      #1;
      check("rsp_hold", 64'({rsp_valid, req_ready, rsp_err, rsp_timeout, rsp_rdata}),
            64'({1'b1, 1'b0, exp_err, exp_to, exp_rd}));
    end
    rsp_ready = 1'b1;
    @(posedge PCLK);
    #1;
    rsp_ready = 1'b0;
    check("rsp_release", 64'({rsp_valid, req_ready}), 64'(2'b01));
    slv_stuck = 1'b0;
    slv_err   = 1'b0;
  endtask

  task automatic reset_mid_access();
    slv_stuck = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0008;
    @(posedge PCLK);
    #1;
    req_valid = 1'b0;
    @(posedge PCLK);
    #1;
    check("rst_in_access", 64'({PSEL, PENABLE}), 64'(2'b11));
    #2;
    PRESETn = 1'b0;
    #1;
    check("rst_async_drop", 64'({PSEL, PENABLE, rsp_valid}), 64'(0));
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn   = 1'b1;
    slv_stuck = 1'b0;
    @(posedge PCLK);
    #1;
    check("rst_release", 64'({req_ready, rsp_valid, PSEL, PENABLE}), 64'(4'b1000));
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK);
      #1;
    end
    check("rst_no_rsp", 64'({req_ready, rsp_valid}), 64'(2'b10));
  endtask

  initial begin
    repeat (3) @(posedge PCLK);
    #1;
    check("reset_ctrl", 64'({req_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE}),
          64'(7'b1000000));
    check("reset_data", 64'({rsp_rdata, PWDATA}), 64'(0));
    check("reset_addr", 64'(PADDR), 64'(0));
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;

    do_req(1'b1, 32'h0, 32'h64, 0, 1'b0, 1'b0, 0);             // zero-wait write
    do_req(1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 0);              // read back 0x64
    do_req(1'b1, 32'h10, 32'hCAFE_0001, 0, 1'b0, 1'b0, 0);
    do_req(1'b0, 32'h10, 32'h0, 3, 1'b0, 1'b0, 0);             // three wait states
    do_req(1'b0, 32'h20, 32'h0, 0, 1'b1, 1'b0, 0);             // stuck: timeout
    do_req(1'b0, 32'h10, 32'h0, 15, 1'b0, 1'b0, 0);            // ready on wait cycle 16
    do_req(1'b1, 32'h24, 32'h1234_5678, 16, 1'b0, 1'b0, 0);    // one wait too many
    do_req(1'b1, 32'h04, 32'h5555_AAAA, 0, 1'b0, 1'b1, 0);     // PSLVERR write
    do_req(1'b0, 32'h04, 32'h0, 0, 1'b0, 1'b0, 0);
    do_req(1'b0, 32'h00, 32'h0, 1, 1'b0, 1'b1, 0);             // PSLVERR read
    do_req(1'b0, 32'h6, 32'h0, 0, 1'b0, 1'b0, 0);              // misaligned
    do_req(1'b0, 32'h10, 32'h0, 1, 1'b0, 1'b0, 5);             // backpressure
    reset_mid_access();

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      int          sel;
      int          w;
      bit          st;
      a   = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      sel = $urandom_range(0, 9);
      st  = (sel == 8);
      w   = (sel <= 5) ? sel % 4 : (sel == 6) ? 15 : (sel == 7) ? 16 : 2;
      do_req(1'($urandom_range(0, 1)), a, $urandom, w, st, ($urandom_range(0, 7) == 0),
             $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
